// File: rtl/board_pkg.sv
// ============================================================================
// Module  : board_pkg
// Brief   : Shared board geometry, row type, player sprite and compositor states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package board_pkg;

    localparam int BOARD_W  = 9;
    localparam int BOARD_H  = 16;
    localparam int SPRITE_W = 3;
    localparam int SPRITE_H = 4;
    localparam int POS_W    = 5;

    typedef logic [BOARD_W-1:0] row_t;

    // Sprite rows listed top to bottom; index 0 lands on row BOARD_H-SPRITE_H.
    localparam logic [0:SPRITE_H-1][SPRITE_W-1:0] c_player_sprite = {
        3'b101,
        3'b010,
        3'b111,
        3'b010
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPOSE = 2'd1,
        PUBLISH = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/board_if.sv
// ============================================================================
// Module  : board_if
// Brief   : Request/frame bundle between game logic and the board compositor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface board_if;
    import board_pkg::*;

    logic                             game_Over;
    logic                             update_board;
    logic [POS_W-1:0]                 player_pos;
    logic [0:BOARD_H-1][BOARD_W-1:0]  obstacle_data;
    logic [0:BOARD_H-1][BOARD_W-1:0]  board_data;
    logic                             busy;
    logic                             done;
    logic                             collide;

    modport master (
        output game_Over,
        output update_board,
        output player_pos,
        output obstacle_data,
        input  board_data,
        input  busy,
        input  done,
        input  collide
    );

    modport slave (
        input  game_Over,
        input  update_board,
        input  player_pos,
        input  obstacle_data,
        output board_data,
        output busy,
        output done,
        output collide
    );

endinterface

`default_nettype wire

// File: rtl/board_row_merge.sv
// ============================================================================
// Module  : board_row_merge
// Brief   : Combinational merge of one obstacle row with a shifted sprite row.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module board_row_merge #(
    parameter int ROW_W  = 9,
    parameter int SPR_W  = 3,
    parameter int SHFT_W = 4
) (
    input  wire logic [ROW_W-1:0]  i_obs_row,
    input  wire logic [SPR_W-1:0]  i_spr_row,
    input  wire logic [SHFT_W-1:0] i_shift,
    input  wire logic              i_in_sprite,
    output logic      [ROW_W-1:0]  o_row,
    output logic                   o_hit
);

    logic [ROW_W-1:0] w_spr_shifted;

    // Widen before shifting so bits pushed past the left edge are simply lost.
    always_comb begin
        w_spr_shifted = '0;
        if (i_in_sprite) begin
            w_spr_shifted = ROW_W'(i_spr_row) << i_shift;
        end
    end

    assign o_row = i_obs_row | w_spr_shifted;
    assign o_hit = |(i_obs_row & w_spr_shifted);

endmodule

`default_nettype wire

// File: rtl/board_compositor.sv
// ============================================================================
// Module  : board_compositor
// Brief   : Composes obstacle field + player sprite one row per clock into a
//           shadow frame and publishes it atomically. Optional collision
//           reporting enabled with `define BOARD_COLLIDE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module board_compositor
    import board_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset,
    board_if.slave    bus
);

    localparam int ROW_W     = $clog2(BOARD_H);
    localparam int SHIFT_W   = $clog2(BOARD_W);
    localparam int SPR_IDX_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int MAX_POS   = BOARD_W / SPRITE_W - 1;
    localparam int SPR_TOP   = BOARD_H - SPRITE_H;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [ROW_W-1:0]                r_row;
    logic [POS_W-1:0]                r_pos;
    logic [0:BOARD_H-1][BOARD_W-1:0] r_snap;
    logic [0:BOARD_H-1][BOARD_W-1:0] r_shadow;
    logic [0:BOARD_H-1][BOARD_W-1:0] r_board;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_collide;

    logic                            w_start;
    logic                            w_last_row;
    logic                            w_in_sprite;
    logic [SPR_IDX_W-1:0]            w_spr_idx;
    logic [SHIFT_W-1:0]              w_shift;
    logic [POS_W-1:0]                w_pos_clamped;
    row_t                            w_merged;
    logic                            w_hit;
    logic                            w_collide_nxt;

    assign w_start       = (r_state == IDLE) && bus.update_board && !bus.game_Over;
    assign w_last_row    = (r_row == ROW_W'(BOARD_H - 1));
    assign w_in_sprite   = (r_row >= ROW_W'(SPR_TOP));
    assign w_spr_idx     = SPR_IDX_W'(r_row - ROW_W'(SPR_TOP));
    assign w_pos_clamped = (bus.player_pos > POS_W'(MAX_POS)) ? POS_W'(MAX_POS) : bus.player_pos;
    assign w_shift       = SHIFT_W'(SPRITE_W * r_pos);

    board_row_merge #(
        .ROW_W  (BOARD_W),
        .SPR_W  (SPRITE_W),
        .SHFT_W (SHIFT_W)
    ) u_row_merge (
        .i_obs_row   (r_snap[r_row]),
        .i_spr_row   (c_player_sprite[w_spr_idx]),
        .i_shift     (w_shift),
        .i_in_sprite (w_in_sprite),
        .o_row       (w_merged),
        .o_hit       (w_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)    w_state_nxt = COMPOSE;
            COMPOSE: if (w_last_row) w_state_nxt = PUBLISH;
            PUBLISH:                 w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_collide <= 1'b0;
            r_board   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_row  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                COMPOSE: begin
                    r_row <= r_row + ROW_W'(1);
                end
                PUBLISH: begin
                    r_board   <= r_shadow;
                    r_collide <= w_collide_nxt;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Snapshot and shadow frame carry no reset: they are always rewritten before use.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_snap <= bus.obstacle_data;
            r_pos  <= w_pos_clamped;
        end
        if (r_state == COMPOSE) begin
            r_shadow[r_row] <= w_merged;
        end
    end

`ifdef BOARD_COLLIDE_EN
    logic r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= 1'b0;
        end else if (w_start) begin
            r_acc <= 1'b0;
        end else if (r_state == COMPOSE) begin
            r_acc <= r_acc | w_hit;
        end
    end

    assign w_collide_nxt = r_acc;
`else
    logic w_unused_hit;
    assign w_unused_hit  = w_hit;
    assign w_collide_nxt = 1'b0;
`endif

    assign bus.board_data = r_board;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.collide    = r_collide;

endmodule

`default_nettype wire

// File: tb/tb_board_compositor.sv
// ============================================================================
// Module  : tb_board_compositor
// Brief   : Directed self-checking bench for board_compositor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_board_compositor;
    import board_pkg::*;

`ifdef BOARD_COLLIDE_EN
    localparam logic [31:0] c_col_en = 32'd1;
`else
    localparam logic [31:0] c_col_en = 32'd0;
`endif

    logic clk = 1'b0;
    logic reset;

    board_if bus();

    board_compositor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [0:BOARD_H-1][BOARD_W-1:0] exp_frame;
    int edges;
    int busy_cycles;
    int n_busy;
    int n_done;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic check_frame(input string tag);
        for (int r = 0; r < BOARD_H; r++)
            check($sformatf("%s_row%0d", tag, r), 32'(bus.board_data[r]), 32'(exp_frame[r]));
    endtask

    // Pulse update_board for one edge, then wait (bounded) for done.
    task automatic run_frame(input string tag, output int n_edges, output int n_busy_cyc);
        logic seen;
        seen       = 1'b0;
        n_edges    = 0;
        n_busy_cyc = 0;
        @(negedge clk) bus.update_board = 1'b1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            bus.update_board = 1'b0;
            n_edges++;
            if (bus.busy) n_busy_cyc++;
            if (bus.done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    endtask

    task automatic set_obst_lin(input int base, input int step);
        for (int i = 0; i < BOARD_H; i++) bus.obstacle_data[i] = BOARD_W'(base + step * i);
    endtask

    initial begin
        reset             = 1'b0;
        bus.game_Over     = 1'b0;
        bus.update_board  = 1'b0;
        bus.player_pos    = '0;
        bus.obstacle_data = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_busy",    32'(bus.busy), 32'd0);
        check("rst_done",    32'(bus.done), 32'd0);
        check("rst_collide", 32'(bus.collide), 32'd0);
        check("rst_board_nz", 32'(bus.board_data != '0), 32'd0);
        @(negedge clk) reset = 1'b1;

        // Basic frame, pos=1: sprite shifted by 3 onto rows 12..15
        bus.player_pos = 5'd1;
        set_obst_lin(8, 5);
        run_frame("t1", edges, busy_cycles);
        check("t1_latency", 32'(edges), 32'd18);
        check("t1_busy_cycles", 32'(busy_cycles), 32'd17);
        for (int i = 0; i < 12; i++) exp_frame[i] = BOARD_W'(8 + 5 * i);
        exp_frame[12] = 9'd108;
        exp_frame[13] = 9'd89;
        exp_frame[14] = 9'd126;
        exp_frame[15] = 9'd83;
        check_frame("t1");
        check("t1_collide", 32'(bus.collide), c_col_en);
        @(posedge clk); #1;
        check("t1_done_pulse", 32'(bus.done), 32'd0);

        // game over blocks requests
        bus.game_Over = 1'b1;
        n_busy = 0;
        n_done = 0;
        @(negedge clk) bus.update_board = 1'b1;
        for (int k = 0; k < 22; k++) begin
            @(posedge clk); #1;
            if (k == 2) bus.update_board = 1'b0;
            if (bus.busy) n_busy++;
            if (bus.done) n_done++;
        end
        check("go_busy", 32'(n_busy), 32'd0);
        check("go_done", 32'(n_done), 32'd0);
        check_frame("go");
        bus.game_Over = 1'b0;

        // Clamp: pos=7 behaves as pos=2
        bus.obstacle_data = '0;
        bus.player_pos    = 5'd7;
        run_frame("t3a", edges, busy_cycles);
        exp_frame     = '0;
        exp_frame[12] = 9'd320;
        exp_frame[13] = 9'd128;
        exp_frame[14] = 9'd448;
        exp_frame[15] = 9'd128;
        check_frame("t3a");
        check("t3a_collide", 32'(bus.collide), 32'd0);
        bus.player_pos = 5'd2;
        run_frame("t3b", edges, busy_cycles);
        check_frame("t3b");

        // Snapshot: inputs change and extra request arrive mid-COMPOSE
        set_obst_lin(0, 1);
        bus.player_pos = 5'd0;
        for (int i = 0; i < 12; i++) exp_frame[i] = BOARD_W'(i);
        exp_frame[12] = 9'd13;
        exp_frame[13] = 9'd15;
        exp_frame[14] = 9'd15;
        exp_frame[15] = 9'd15;
        n_done = 0;
        @(negedge clk) bus.update_board = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (k == 0) bus.update_board = 1'b0;
            if (k == 5) begin
                bus.obstacle_data = {BOARD_H{9'h1FF}};
                bus.player_pos    = 5'd2;
                bus.update_board  = 1'b1;
            end
            if (k == 7) bus.update_board = 1'b0;
            if (bus.done) begin
                n_done++;
                if (n_done == 1) check_frame("t4");
            end
        end
        check("t4_done_count", 32'(n_done), 32'd1);
        check("t4_collide", 32'(bus.collide), c_col_en);

        // Collision set then cleared on the following frame
        bus.obstacle_data     = '0;
        bus.obstacle_data[15] = 9'b000_000_010;
        bus.player_pos        = 5'd0;
        run_frame("t5a", edges, busy_cycles);
        exp_frame     = '0;
        exp_frame[12] = 9'd5;
        exp_frame[13] = 9'd2;
        exp_frame[14] = 9'd7;
        exp_frame[15] = 9'd2;
        check_frame("t5a");
        check("t5a_collide", 32'(bus.collide), c_col_en);
        bus.obstacle_data[15] = '0;
        run_frame("t5b", edges, busy_cycles);
        check("t5b_row15", 32'(bus.board_data[15]), 32'd2);
        check("t5b_collide", 32'(bus.collide), 32'd0);

        // Reset asserted while composing row 8
        @(negedge clk) bus.update_board = 1'b1;
        @(posedge clk); #1;
        bus.update_board = 1'b0;
        repeat (8) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy",    32'(bus.busy), 32'd0);
        check("mid_rst_done",    32'(bus.done), 32'd0);
        check("mid_rst_collide", 32'(bus.collide), 32'd0);
        check("mid_rst_board_nz", 32'(bus.board_data != '0), 32'd0);
        @(negedge clk) reset = 1'b1;
        bus.player_pos = 5'd1;
        set_obst_lin(8, 5);
        run_frame("t6", edges, busy_cycles);
        check("t6_latency", 32'(edges), 32'd18);
        for (int i = 0; i < 12; i++) exp_frame[i] = BOARD_W'(8 + 5 * i);
        exp_frame[12] = 9'd108;
        exp_frame[13] = 9'd89;
        exp_frame[14] = 9'd126;
        exp_frame[15] = 9'd83;
        check_frame("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
